daq_pulse_reader: RTL
=====================

DAQ_PULSE_READER -- requirements
Module: daq_pulse_reader

Interface
REQ-001 SHALL have parameter DEPTH, default 4, summary FIFO depth (power of 2, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port word  input  32  packed bin word {live[31], spill[30], nspills[29:21], ibin[20:13], nhits[12:0]}, synchronous to clk.
REQ-005 SHALL have port bin_valid  output  1  one-cycle strobe per new bin decoded.
REQ-006 SHALL have port bin_hits  output  13  nhits of the last decoded bin.
REQ-007 SHALL have port bin_idx  output  8  ibin of the last decoded bin.
REQ-008 SHALL have port fifo_dout  output  48  head spill summary {nspills[47:39], gaps[38:32], nbins[31:24], hits[23:0]}, first-word-fall-through.
REQ-009 SHALL have port fifo_empty  output  1  FIFO holds no entry.
REQ-010 SHALL have port rd_en  input  1  pop head entry at this edge.
REQ-011 SHALL have port overflow  output  1  sticky: a summary was dropped on a full FIFO.

Function
REQ-012 SHALL register word into word_q every cycle; all decoding uses word_q.
REQ-013 SHALL declare a new bin when word_q[20:13] differs from the last accepted ibin, or on the first word after reset leaves IDLE.
REQ-014 SHALL pulse bin_valid the cycle after word_q shows a new bin (2 cycles after word changes), with bin_hits/bin_idx updated in the same cycle and held until the next bin.
REQ-015 SHALL implement states IDLE, OFF, ON, FLUSH.
REQ-016 IDLE: first cycle after reset release latches ibin as last ibin, no bin_valid; -> OFF if spill=0, else -> ON with accumulators cleared.
REQ-017 OFF: new bin with spill=1 -> ON; clear accumulators, then add that bin (hits+=nhits, nbins=1).
REQ-018 ON: new bin with spill=1 -> hits+=nhits, nbins+=1; new bin with spill=0 -> FLUSH, that bin not accumulated.
REQ-019 FLUSH: one cycle; pushes {nspills of last ON bin, gaps, nbins, hits}; -> OFF unconditionally.
REQ-020 hits SHALL saturate at 0xFFFFFF, nbins at 255, gaps at 127; no wrap.
REQ-021 Expected ibin SHALL be (last ibin + 1) mod 256; 255->0 is not a gap.
REQ-022 Push with FIFO full and no rd_en SHALL drop the entry and set overflow; push with full and rd_en SHALL pop then accept the push.
REQ-023 rd_en while fifo_empty SHALL be ignored, no pointer change.
REQ-024 Pushed entry SHALL be visible on fifo_dout, fifo_empty low, the cycle after FLUSH.

Reset
REQ-025 Asserting rst SHALL immediately force state IDLE, FIFO empty (fifo_empty=1), fifo_dout=0, bin_valid=0, bin_hits=0, bin_idx=0, overflow=0, accumulators=0, word_q=0.
REQ-026 Reset mid-spill SHALL discard the partial spill without pushing a summary.

Configuration
REQ-027 Macro DAQ_PULSE_READER_GAPCHK_EN defined SHALL enable gap detection: each new bin whose ibin != expected increments gaps while ON.
REQ-028 Macro undefined SHALL remove the gap logic; fifo_dout[38:32] SHALL read 0.

Verification
REQ-029 Spill=1 bins ibin 10,11,12 with nhits 5,7,9, then spill=0 bin 13 -> one entry hits=21, nbins=3, gaps=0; bin_valid pulsed 4 times.
REQ-030 With GAPCHK_EN: ON bins ibin 254,255,0,2 then spill=0 -> gaps=1, nbins=4.
REQ-031 Nhits 0x1FFF for 2100 ON bins -> hits=0xFFFFFF, nbins=255.
REQ-032 DEPTH=4, 5 spills with rd_en low -> 4 entries kept, overflow=1; then 4 pops -> fifo_empty=1 after fourth.
REQ-033 FIFO full, rd_en high in FLUSH cycle -> head pops, new entry accepted, overflow stays 0.
REQ-034 rst low during ON after 3 bins -> outputs zero immediately; after release no entry pushed, fifo_empty=1.

Source files
------------

// File: rtl/daq_pulse_reader.sv
// daq_pulse_reader
//   Decodes a stream of packed per-bin DAQ words. Each new bin is reported on
//   bin_valid/bin_hits/bin_idx. Runs of spill=1 bins are gathered into one spill
//   summary, and each summary is queued in a small first-word-fall-through FIFO.
//   Optional build macro: DAQ_PULSE_READER_GAPCHK_EN counts missing bin indices
//   in each spill. With the macro undefined, the gaps field of every summary is 0.
// Ports:
//   clk         sole clock, rising edge
//   rst         asynchronous reset, active low
//   word        {live[31], spill[30], nspills[29:21], ibin[20:13], nhits[12:0]}
//   bin_valid   one-cycle strobe per decoded bin
//   bin_hits    nhits of the last decoded bin
//   bin_idx     ibin of the last decoded bin
//   fifo_dout   head summary {nspills[47:39], gaps[38:32], nbins[31:24], hits[23:0]}
//   fifo_empty  FIFO holds no entry
//   rd_en       pop the head entry at this edge (ignored when empty)
//   overflow    sticky; set when a summary was dropped because the FIFO was full
module daq_pulse_reader #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] word,
   output logic        bin_valid,
   output logic [12:0] bin_hits,
   output logic [7:0]  bin_idx,
   output logic [47:0] fifo_dout,
   output logic        fifo_empty,
   input  logic        rd_en,
   output logic        overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef struct packed {
      logic [8:0]  nspills;
      logic [6:0]  gaps;
      logic [7:0]  nbins;
      logic [23:0] hits;
   } summary_t;

   typedef enum logic [1:0] {ST_IDLE, ST_OFF, ST_ON, ST_FLUSH} state_e;

   state_e      state_q;
   logic [31:0] word_q;
   logic        first_q;
   logic [7:0]  last_ibin_q;
   logic        bin_valid_q;
   logic [12:0] bin_hits_q;
   logic [7:0]  bin_idx_q;
   logic [23:0] hits_q;
   logic [7:0]  nbins_q;
   logic [8:0]  nsp_q;

   // Decoded fields of the registered word
   logic        spill_c;
   logic [8:0]  nspills_c;
   logic [7:0]  ibin_c;
   logic [12:0] nhits_c;
   logic        live_unused;
   logic        new_bin_c;

   assign live_unused = word_q[31];
   assign spill_c     = word_q[30];
   assign nspills_c   = word_q[29:21];
   assign ibin_c      = word_q[20:13];
   assign nhits_c     = word_q[12:0];

   // The first word seen after IDLE always counts as a new bin
   assign new_bin_c = (state_q != ST_IDLE) && (first_q || (ibin_c != last_ibin_q));

   // Saturating accumulator updates
   logic [24:0] hits_sum;
   logic [23:0] hits_d;
   logic [7:0]  nbins_d;
   always_comb begin
      hits_sum = {1'b0, hits_q} + 25'(nhits_c);
      hits_d   = hits_sum[24] ? 24'hFF_FFFF : hits_sum[23:0];
      nbins_d  = (nbins_q == 8'hFF) ? 8'hFF : nbins_q + 8'd1;
   end

`ifdef DAQ_PULSE_READER_GAPCHK_EN
   logic [6:0] gaps_q;
   logic [6:0] gaps_d;
   logic       gap_c;
   // 255 -> 0 is the natural successor, so the 8-bit add wraps on purpose
   assign gap_c  = (ibin_c != (last_ibin_q + 8'd1));
   assign gaps_d = (gaps_q == 7'h7F) ? 7'h7F : gaps_q + 7'd1;
`endif

   // Bin decode and spill accumulation FSM
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         word_q      <= '0;
         first_q     <= 1'b0;
         last_ibin_q <= '0;
         bin_valid_q <= 1'b0;
         bin_hits_q  <= '0;
         bin_idx_q   <= '0;
         hits_q      <= '0;
         nbins_q     <= '0;
         nsp_q       <= '0;
`ifdef DAQ_PULSE_READER_GAPCHK_EN
         gaps_q      <= '0;
`endif
      end else begin
         word_q      <= word;
         first_q     <= (state_q == ST_IDLE);
         bin_valid_q <= new_bin_c;
         if (new_bin_c) begin
            bin_hits_q  <= nhits_c;
            bin_idx_q   <= ibin_c;
            last_ibin_q <= ibin_c;
         end
         case (state_q)
            ST_IDLE: begin
               last_ibin_q <= ibin_c;
               hits_q      <= '0;
               nbins_q     <= '0;
               nsp_q       <= '0;
`ifdef DAQ_PULSE_READER_GAPCHK_EN
               gaps_q      <= '0;
`endif
               state_q     <= spill_c ? ST_ON : ST_OFF;
            end
            ST_OFF: begin
               // Opening bin of a spill starts fresh accumulators
               if (new_bin_c && spill_c) begin
                  state_q <= ST_ON;
                  hits_q  <= 24'(nhits_c);
                  nbins_q <= 8'd1;
                  nsp_q   <= nspills_c;
`ifdef DAQ_PULSE_READER_GAPCHK_EN
                  gaps_q  <= '0;
`endif
               end
            end
            ST_ON: begin
               if (new_bin_c) begin
                  if (spill_c) begin
                     hits_q  <= hits_d;
                     nbins_q <= nbins_d;
                     nsp_q   <= nspills_c;
`ifdef DAQ_PULSE_READER_GAPCHK_EN
                     if (gap_c) gaps_q <= gaps_d;
`endif
                  end else begin
                     state_q <= ST_FLUSH;
                  end
               end
            end
            ST_FLUSH: state_q <= ST_OFF;
            default:  state_q <= ST_IDLE;
         endcase
      end
   end

   assign bin_valid = bin_valid_q;
   assign bin_hits  = bin_hits_q;
   assign bin_idx   = bin_idx_q;

   // Summary entry presented to the FIFO during FLUSH
   summary_t entry_c;
   always_comb begin
      entry_c.nspills = nsp_q;
`ifdef DAQ_PULSE_READER_GAPCHK_EN
      entry_c.gaps    = gaps_q;
`else
      entry_c.gaps    = '0;
`endif
      entry_c.nbins   = nbins_q;
      entry_c.hits    = hits_q;
   end

   // Summary FIFO
   logic [47:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          overflow_q;
   logic          push_c;
   logic          pop_c;
   logic          empty_c;
   logic          full_c;
   logic          accept_c;

   assign push_c   = (state_q == ST_FLUSH);
   assign empty_c  = (count_q == '0);
   assign full_c   = (count_q == CW'(DEPTH));
   assign pop_c    = rd_en && !empty_c;
   // A pop in the same cycle frees the slot for a push into a full FIFO
   assign accept_c = push_c && (!full_c || pop_c);

   always_ff @(posedge clk) begin
      if (accept_c) mem_q[wr_ptr_q] <= entry_c;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (accept_c) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_c)    rd_ptr_q <= rd_ptr_q + AW'(1);
         if (accept_c && !pop_c)      count_q <= count_q + CW'(1);
         else if (!accept_c && pop_c) count_q <= count_q - CW'(1);
         if (push_c && !accept_c) overflow_q <= 1'b1;
      end
   end

   // Empty FIFO reads as zero so stale storage never leaks out
   assign fifo_dout  = empty_c ? '0 : mem_q[rd_ptr_q];
   assign fifo_empty = empty_c;
   assign overflow   = overflow_q;

endmodule
